// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: FSM state encoding
// and the pointer-advance helper used for both read and write addresses.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        NORMAL = 2'b01,
        FULL   = 2'b10
    } state_t;

    // Depth need not be a power of two, so wrap explicitly instead of relying on overflow.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// B x DEPTH simple dual-port storage: synchronous write, registered read with
// read-enable. The read register clears on clr; the array itself is never reset.
module fifo_ram #(
    parameter int B     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] w_addr,
    input  logic [B-1:0]  w_data,
    input  logic          re,
    input  logic [AW-1:0] r_addr,
    output logic [B-1:0]  r_data
);

    logic [B-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[w_addr] <= w_data;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_data <= '0;
        else if (re)
            r_data <= mem[r_addr];
    end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count, almost flags and a 1-cycle
// registered read. Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_sync_param #(
    parameter int B      = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 8,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [B-1:0]  wr_data,
    input  logic          rd_en,
    output logic [B-1:0]  rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic          overflow,
    output logic          underflow,
`endif
    output logic [AW-1:0] count
);

    import fifo_pkg::*;

    localparam int IW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 256 || (2 ** AW) <= DEPTH) begin : g_bad_params
        $error("fifo_sync_param: DEPTH must be 2..256 and 2**AW > DEPTH");
    end

    state_t        state;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] count_next;
    logic          wr_acc;
    logic          rd_acc;

    assign empty  = (state == EMPTY);
    assign full   = (state == FULL);
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc)
            count_next = count + AW'(1);
        else if (rd_acc && !wr_acc)
            count_next = count - AW'(1);
    end

    // Almost flags come from count_next so they line up with count in the same cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= EMPTY;
            w_addr       <= '0;
            r_addr       <= '0;
            count        <= '0;
            rd_valid     <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_next;
            rd_valid     <= rd_acc;
            almost_full  <= (count_next >= AW'(AF_LVL));
            almost_empty <= (count_next <= AW'(AE_LVL));
            if (wr_acc)
                w_addr <= AW'(ptr_next(32'(w_addr), DEPTH));
            if (rd_acc)
                r_addr <= AW'(ptr_next(32'(r_addr), DEPTH));
            case (state)
                EMPTY:  if (wr_acc) state <= NORMAL;
                NORMAL: begin
                    if (wr_acc && !rd_acc && count == AW'(DEPTH - 1))
                        state <= FULL;
                    else if (rd_acc && !wr_acc && count == AW'(1))
                        state <= EMPTY;
                end
                FULL:   if (rd_acc) state <= NORMAL;
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end
`endif

    fifo_ram #(
        .B     (B),
        .DEPTH (DEPTH),
        .AW    (IW)
    ) u_ram (
        .clk    (clk),
        .clr    (clr),
        .we     (wr_acc),
        .w_addr (w_addr[IW-1:0]),
        .w_data (wr_data),
        .re     (rd_acc),
        .r_addr (r_addr[IW-1:0]),
        .r_data (rd_data)
    );

endmodule
